// File: rtl/scv_pkg.sv
// Shared constants and types for the Super Cassette Vision core and its ROM loader.
package scv_pkg;

    localparam logic [7:0] IDX_BIOS_DEF = 8'h00;
    localparam logic [7:0] IDX_CART_DEF = 8'h01;

    localparam logic [24:0] BOOT_BASE = 25'h000_0000;
    localparam logic [24:0] BOOT_SIZE = 25'h000_1000;
    localparam logic [24:0] CHR_BASE  = 25'h000_1000;
    localparam logic [24:0] CHR_SIZE  = 25'h000_0400;
    localparam logic [24:0] CART_MAX  = 25'h002_0000;

    typedef enum logic [1:0] {IDLE, LO, HI} rominit_st_t;
    typedef enum logic [1:0] {RUN, LOAD, HOLD} rst_st_t;

    typedef struct packed {
        logic        boot;
        logic        chr;
        logic        cart;
        logic [24:0] addr;
    } region_t;

endpackage

// File: rtl/ioctl_skid.sv
// One-word holding buffer for ioctl writes that arrive while the byte emitter is busy.
module ioctl_skid (
    input  logic        CLK,
    input  logic        RST,
    input  logic        push,
    input  logic        pop,
    input  logic [24:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic [7:0]  wr_idx,
    output logic [24:0] addr,
    output logic [15:0] data,
    output logic [7:0]  idx,
    output logic        full,
    output logic        ovf
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            full <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            // A push into a full buffer is a host violation: the word is lost.
            if (push && full)
                ovf <= 1'b1;
            if (push && !full)
                full <= 1'b1;
            else if (pop)
                full <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !full) begin
            addr <= wr_addr;
            data <= wr_data;
            idx  <= wr_idx;
        end
    end

endmodule

// File: rtl/rominit_loader.sv
// Splits the 16-bit ioctl download into ROMINIT byte writes, tracks cart size and
// holds the console in reset during and shortly after a download.
module rominit_loader
    import scv_pkg::*;
#(
    parameter int         HOLD_CYCLES = 64,
    parameter logic [7:0] IDX_BIOS    = IDX_BIOS_DEF,
    parameter logic [7:0] IDX_CART    = IDX_CART_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IOCTL_DOWNLOAD,
    input  logic [7:0]  IOCTL_INDEX,
    input  logic        IOCTL_WR,
    input  logic [24:0] IOCTL_ADDR,
    input  logic [15:0] IOCTL_DOUT,
    output logic        IOCTL_WAIT,
    output logic        ROMINIT_SEL_BOOT,
    output logic        ROMINIT_SEL_CHR,
    output logic        ROMINIT_SEL_CART,
    output logic [24:0] ROMINIT_ADDR,
    output logic [7:0]  ROMINIT_DATA,
    output logic        ROMINIT_VALID,
    output logic        SCV_RESB,
    output logic [17:0] CART_SIZE
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    rominit_st_t st, st_n;
    rst_st_t     rs, rs_n;
    logic [CNT_W-1:0] hold_cnt;

    logic [24:0] cur_addr;
    logic [7:0]  cur_hi;
    logic [7:0]  cur_idx;

    logic [24:0] sk_addr;
    logic [15:0] sk_data;
    logic [7:0]  sk_idx;
    logic        sk_full, sk_push, sk_pop, full_n;
    logic        skid_ovf_unused;

    logic [24:0] w_addr;
    logic [15:0] w_data;
    logic [7:0]  w_idx;
    logic        take_skid, take_in;

    logic [24:0] byte_addr_p0;
    logic [7:0]  byte_data_p0;
    logic [7:0]  byte_idx_p0;
    logic        vld_p0, hit_p0;
    region_t     reg_p0;
    logic [17:0] cart_cand_p0;

    logic        dl_q;

    function automatic region_t decode(input logic [7:0] idx, input logic [24:0] b);
        region_t r;
        r = '0;
        if (idx == IDX_BIOS && b < BOOT_BASE + BOOT_SIZE) begin
            r.boot = 1'b1;
            r.addr = b - BOOT_BASE;
        end else if (idx == IDX_BIOS && b >= CHR_BASE && b < CHR_BASE + CHR_SIZE) begin
            r.chr  = 1'b1;
            r.addr = b - CHR_BASE;
        end else if (idx == IDX_CART && b < CART_MAX) begin
            r.cart = 1'b1;
            r.addr = b;
        end
        return r;
    endfunction

    ioctl_skid u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .push    (sk_push),
        .pop     (sk_pop),
        .wr_addr (IOCTL_ADDR),
        .wr_data (IOCTL_DOUT),
        .wr_idx  (IOCTL_INDEX),
        .addr    (sk_addr),
        .data    (sk_data),
        .idx     (sk_idx),
        .full    (sk_full),
        .ovf     (skid_ovf_unused)
    );

    assign w_addr = sk_full ? sk_addr : IOCTL_ADDR;
    assign w_data = sk_full ? sk_data : IOCTL_DOUT;
    assign w_idx  = sk_full ? sk_idx  : IOCTL_INDEX;

    assign sk_push = IOCTL_WR && !take_in;
    assign sk_pop  = take_skid;
    assign full_n  = (sk_push && !sk_full) || (sk_full && !sk_pop);

    // Stage p0: choose the byte for the next cycle; outputs register it below.
    always_comb begin
        st_n         = st;
        take_skid    = 1'b0;
        take_in      = 1'b0;
        byte_addr_p0 = '0;
        byte_data_p0 = '0;
        byte_idx_p0  = '0;
        vld_p0       = 1'b0;
        case (st)
            IDLE, HI: begin
                if (sk_full) begin
                    take_skid = 1'b1;
                    st_n      = LO;
                end else if (IOCTL_WR) begin
                    take_in = 1'b1;
                    st_n    = LO;
                end else begin
                    st_n = IDLE;
                end
            end
            LO:      st_n = HI;
            default: st_n = IDLE;
        endcase
        if (st_n == LO) begin
            byte_addr_p0 = w_addr;
            byte_data_p0 = w_data[7:0];
            byte_idx_p0  = w_idx;
            vld_p0       = 1'b1;
        end else if (st_n == HI) begin
            byte_addr_p0 = cur_addr + 25'd1;
            byte_data_p0 = cur_hi;
            byte_idx_p0  = cur_idx;
            vld_p0       = 1'b1;
        end
    end

    assign reg_p0       = decode(byte_idx_p0, byte_addr_p0);
    assign hit_p0       = vld_p0 && (reg_p0.boot || reg_p0.chr || reg_p0.cart);
    assign cart_cand_p0 = byte_addr_p0[17:0] + 18'd1;

    always_ff @(posedge CLK) begin
        if (take_skid || take_in) begin
            cur_addr <= w_addr;
            cur_hi   <= w_data[15:8];
            cur_idx  <= w_idx;
        end
    end

    // Stage p1: registered ROMINIT outputs, backpressure and cart size.
    always_ff @(posedge CLK) begin
        if (RST) begin
            st               <= IDLE;
            IOCTL_WAIT       <= 1'b0;
            ROMINIT_VALID    <= 1'b0;
            ROMINIT_SEL_BOOT <= 1'b0;
            ROMINIT_SEL_CHR  <= 1'b0;
            ROMINIT_SEL_CART <= 1'b0;
            ROMINIT_ADDR     <= '0;
            ROMINIT_DATA     <= '0;
            CART_SIZE        <= '0;
            dl_q             <= 1'b0;
        end else begin
            st               <= st_n;
            IOCTL_WAIT       <= (st_n != IDLE) || full_n;
            ROMINIT_VALID    <= hit_p0;
            ROMINIT_SEL_BOOT <= hit_p0 && reg_p0.boot;
            ROMINIT_SEL_CHR  <= hit_p0 && reg_p0.chr;
            ROMINIT_SEL_CART <= hit_p0 && reg_p0.cart;
            if (hit_p0) begin
                ROMINIT_ADDR <= reg_p0.addr;
                ROMINIT_DATA <= byte_data_p0;
            end
            dl_q <= IOCTL_DOWNLOAD;
            if (IOCTL_DOWNLOAD && !dl_q && IOCTL_INDEX == IDX_CART)
                CART_SIZE <= '0;
            else if (hit_p0 && reg_p0.cart && cart_cand_p0 > CART_SIZE)
                CART_SIZE <= cart_cand_p0;
        end
    end

    // The drain check looks at next-cycle emitter state so the hold starts
    // on the edge that retires the final byte.
    always_comb begin
        rs_n = rs;
        case (rs)
            RUN:  if (IOCTL_DOWNLOAD) rs_n = LOAD;
            LOAD: if (!IOCTL_DOWNLOAD && st_n == IDLE && !full_n) rs_n = HOLD;
            HOLD: begin
                if (IOCTL_DOWNLOAD)
                    rs_n = LOAD;
                else if (hold_cnt == '0)
                    rs_n = RUN;
            end
            default: rs_n = HOLD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rs       <= HOLD;
            hold_cnt <= HOLD_LOAD;
            SCV_RESB <= 1'b0;
        end else begin
            rs <= rs_n;
            if (rs == LOAD && rs_n == HOLD)
                hold_cnt <= HOLD_LOAD;
            else if (rs == HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - CNT_W'(1);
            SCV_RESB <= (rs_n == RUN);
        end
    end

endmodule

// File: tb/tb_rominit_loader.sv
// Directed bench for rominit_loader: byte split, region decode, skid, cart size, reset hold.
module tb_rominit_loader;

    localparam int H = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IOCTL_DOWNLOAD;
    logic [7:0]  IOCTL_INDEX;
    logic        IOCTL_WR;
    logic [24:0] IOCTL_ADDR;
    logic [15:0] IOCTL_DOUT;
    logic        IOCTL_WAIT;
    logic        ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART;
    logic [24:0] ROMINIT_ADDR;
    logic [7:0]  ROMINIT_DATA;
    logic        ROMINIT_VALID;
    logic        SCV_RESB;
    logic [17:0] CART_SIZE;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_vld = 0;

    rominit_loader #(.HOLD_CYCLES(H)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .IOCTL_DOWNLOAD   (IOCTL_DOWNLOAD),
        .IOCTL_INDEX      (IOCTL_INDEX),
        .IOCTL_WR         (IOCTL_WR),
        .IOCTL_ADDR       (IOCTL_ADDR),
        .IOCTL_DOUT       (IOCTL_DOUT),
        .IOCTL_WAIT       (IOCTL_WAIT),
        .ROMINIT_SEL_BOOT (ROMINIT_SEL_BOOT),
        .ROMINIT_SEL_CHR  (ROMINIT_SEL_CHR),
        .ROMINIT_SEL_CART (ROMINIT_SEL_CART),
        .ROMINIT_ADDR     (ROMINIT_ADDR),
        .ROMINIT_DATA     (ROMINIT_DATA),
        .ROMINIT_VALID    (ROMINIT_VALID),
        .SCV_RESB         (SCV_RESB),
        .CART_SIZE        (CART_SIZE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (ROMINIT_VALID === 1'b1)
            last_vld = cyc;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // sel is {BOOT, CHR, CART}
    task automatic chk_byte(input string tag, input logic [2:0] sel, input logic [24:0] a,
                            input logic [7:0] d);
        chk(tag, 64'({ROMINIT_VALID, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
                      ROMINIT_ADDR, ROMINIT_DATA}),
            64'({1'b1, sel, a, d}));
    endtask

    task automatic wr_word(input logic [7:0] idx, input logic [24:0] a, input logic [15:0] d);
        IOCTL_WR    = 1'b1;
        IOCTL_INDEX = idx;
        IOCTL_ADDR  = a;
        IOCTL_DOUT  = d;
        tick();
        IOCTL_WR = 1'b0;
    endtask

    initial begin
        int n_cart;
        int resb_hi;
        int g;

        RST = 1'b1;
        IOCTL_DOWNLOAD = 1'b0;
        IOCTL_INDEX = 8'h00;
        IOCTL_WR = 1'b0;
        IOCTL_ADDR = '0;
        IOCTL_DOUT = '0;
        tick();
        tick();

        // Reset values
        chk("rst_valid", 64'(ROMINIT_VALID), 64'd0);
        chk("rst_sel", 64'({ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART}), 64'd0);
        chk("rst_addr_data", 64'({ROMINIT_ADDR, ROMINIT_DATA}), 64'd0);
        chk("rst_wait", 64'(IOCTL_WAIT), 64'd0);
        chk("rst_cart_size", 64'(CART_SIZE), 64'd0);
        chk("rst_resb", 64'(SCV_RESB), 64'd0);

        // First RST-low cycle: RESB rises H cycles later
        RST = 1'b0;
        repeat (H - 1) tick();
        chk("resb_hold_low", 64'(SCV_RESB), 64'd0);
        tick();
        chk("resb_rise", 64'(SCV_RESB), 64'd1);

        // BIOS word at the top of boot ROM
        IOCTL_DOWNLOAD = 1'b1;
        IOCTL_INDEX = 8'h00;
        tick();
        wr_word(8'h00, 25'h0FFE, 16'hA55A);
        chk_byte("boot_lo", 3'b100, 25'h0FFE, 8'h5A);
        chk("boot_wait1", 64'(IOCTL_WAIT), 64'd1);
        chk("load_resb", 64'(SCV_RESB), 64'd0);
        tick();
        chk_byte("boot_hi", 3'b100, 25'h0FFF, 8'hA5);
        chk("boot_wait2", 64'(IOCTL_WAIT), 64'd1);
        tick();
        chk("boot_done_valid", 64'(ROMINIT_VALID), 64'd0);
        chk("boot_done_wait", 64'(IOCTL_WAIT), 64'd0);

        // CHR region rebasing, then past its end
        wr_word(8'h00, 25'h1000, 16'h1234);
        chk_byte("chr_lo", 3'b010, 25'h0000, 8'h34);
        tick();
        chk_byte("chr_hi", 3'b010, 25'h0001, 8'h12);
        tick();
        wr_word(8'h00, 25'h1400, 16'hBEEF);
        chk("chr_oob_lo", 64'(ROMINIT_VALID), 64'd0);
        chk("chr_oob_wait", 64'(IOCTL_WAIT), 64'd1);
        tick();
        chk("chr_oob_hi", 64'(ROMINIT_VALID), 64'd0);
        tick();

        // Two consecutive writes: second goes through the skid buffer
        wr_word(8'h01, 25'h0000, 16'h2211);
        chk_byte("skid_b0", 3'b001, 25'h0000, 8'h11);
        wr_word(8'h01, 25'h0002, 16'h4433);
        chk_byte("skid_b1", 3'b001, 25'h0001, 8'h22);
        chk("skid_wait2", 64'(IOCTL_WAIT), 64'd1);
        tick();
        chk_byte("skid_b2", 3'b001, 25'h0002, 8'h33);
        chk("skid_wait3", 64'(IOCTL_WAIT), 64'd1);
        tick();
        chk_byte("skid_b3", 3'b001, 25'h0003, 8'h44);
        chk("skid_wait4", 64'(IOCTL_WAIT), 64'd1);
        chk("skid_ovf_clear", 64'(dut.u_skid.ovf), 64'd0);
        tick();
        chk("skid_done_valid", 64'(ROMINIT_VALID), 64'd0);
        chk("skid_done_wait", 64'(IOCTL_WAIT), 64'd0);

        // Third write while the skid is full is dropped and flagged
        wr_word(8'h01, 25'h0010, 16'h0605);
        wr_word(8'h01, 25'h0012, 16'h0807);
        wr_word(8'h01, 25'h0014, 16'h0A09);
        chk_byte("ovf_b2", 3'b001, 25'h0012, 8'h07);
        chk("ovf_set", 64'(dut.u_skid.ovf), 64'd1);
        tick();
        chk_byte("ovf_b3", 3'b001, 25'h0013, 8'h08);
        tick();
        chk("ovf_dropped", 64'(ROMINIT_VALID), 64'd0);
        chk("ovf_wait", 64'(IOCTL_WAIT), 64'd0);
        chk("cart_size_max", 64'(CART_SIZE), 64'h14);

        // New cart download of 0x8000 bytes
        IOCTL_DOWNLOAD = 1'b0;
        repeat (3) tick();
        IOCTL_DOWNLOAD = 1'b1;
        IOCTL_INDEX = 8'h01;
        tick();
        chk("cart_size_clr", 64'(CART_SIZE), 64'd0);
        n_cart = 0;
        resb_hi = 0;
        for (int i = 0; i < 16384; i++) begin
            IOCTL_WR = 1'b1;
            IOCTL_ADDR = 25'(2 * i);
            IOCTL_DOUT = 16'(i);
            tick();
            IOCTL_WR = 1'b0;
            if (i == 16383)
                IOCTL_DOWNLOAD = 1'b0;
            if (ROMINIT_VALID === 1'b1 && ROMINIT_SEL_CART === 1'b1) n_cart++;
            if (SCV_RESB !== 1'b0) resb_hi = 1;
            tick();
            if (ROMINIT_VALID === 1'b1 && ROMINIT_SEL_CART === 1'b1) n_cart++;
            if (SCV_RESB !== 1'b0) resb_hi = 1;
        end
        chk("cart_bytes", 64'(n_cart), 64'h8000);
        chk("cart_resb_low", 64'(resb_hi), 64'd0);
        chk("cart_size_8000", 64'(CART_SIZE), 64'h8000);
        g = 0;
        while (SCV_RESB !== 1'b1 && g < 4 * H) begin
            tick();
            g++;
        end
        chk("cart_resb_rise", 64'(SCV_RESB), 64'd1);
        // Last byte in cycle L; hold starts on that edge, RESB high from L+1+H
        chk("cart_resb_delay", 64'(cyc - last_vld), 64'(H + 1));

        // Oversize cart: last legal word, then one past the end
        IOCTL_DOWNLOAD = 1'b1;
        IOCTL_INDEX = 8'h01;
        tick();
        chk("big_clr", 64'(CART_SIZE), 64'd0);
        wr_word(8'h01, 25'h1FFFE, 16'hCDAB);
        chk_byte("big_lo", 3'b001, 25'h1FFFE, 8'hAB);
        tick();
        chk_byte("big_hi", 3'b001, 25'h1FFFF, 8'hCD);
        tick();
        wr_word(8'h01, 25'h20000, 16'h1111);
        chk("big_oob_lo", 64'(ROMINIT_VALID), 64'd0);
        tick();
        chk("big_oob_hi", 64'(ROMINIT_VALID), 64'd0);
        tick();
        chk("big_size", 64'(CART_SIZE), 64'h20000);

        // RST during cycle 1 of a word aborts it
        wr_word(8'h01, 25'h0040, 16'h5566);
        chk_byte("abort_lo", 3'b001, 25'h0040, 8'h66);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        IOCTL_DOWNLOAD = 1'b0;
        chk("abort_valid", 64'(ROMINIT_VALID), 64'd0);
        chk("abort_wait", 64'(IOCTL_WAIT), 64'd0);
        chk("abort_resb", 64'(SCV_RESB), 64'd0);
        chk("abort_ovf", 64'(dut.u_skid.ovf), 64'd0);
        chk("abort_cart_size", 64'(CART_SIZE), 64'd0);
        tick();
        chk("abort_no_hi", 64'(ROMINIT_VALID), 64'd0);
        repeat (H - 2) tick();
        chk("abort_resb_low", 64'(SCV_RESB), 64'd0);
        tick();
        chk("abort_resb_rise", 64'(SCV_RESB), 64'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
